// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/ALU/response bundle for alu_share_arbiter
//
// Signals:
//   req0_* / req1_*  : per-requester valid/ready channel carrying a, b, op
//   alu_a/b/op       : registered operands toward the shared ALU
//   alu_res          : result returned by the ALU
//   rsp_*            : shared response channel (data tagged with requester id)
//   busy             : arbiter has an operation in flight
// Modports: slave = arbiter side, master = requester/ALU/consumer side.
interface alu_share_arbiter_if #(
    parameter int DW  = 3,
    parameter int OPW = 3,
    parameter int RW  = 5
);
    logic           req0_valid;
    logic           req0_ready;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic [OPW-1:0] req0_op;
    logic           req1_valid;
    logic           req1_ready;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [RW-1:0]  alu_res;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [RW-1:0]  rsp_data;
    logic           rsp_id;
    logic           busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_res, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_res, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_share_arbiter_if.slave (request channels, ALU drive/result,
//            tagged response channel, busy)
// Parameter ALU_LAT (1..7) is the number of edges between the operand
// transfer edge and the edge that samples alu_res.
module alu_share_arbiter #(
    parameter int DW      = 3,
    parameter int OPW     = 3,
    parameter int RW      = 5,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

    state_t         state_q, state_d;
    logic           prio_q;
    logic [2:0]     cnt_q;
    logic [DW-1:0]  alu_a_q, alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic [RW-1:0]  rsp_data_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;

    logic any_valid;
    logic gnt;
    logic accept;
    logic capture;
    logic rsp_done;

    // With a single valid requester it wins; with both, the pointer decides.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign gnt       = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= 3'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q  <= gnt ? bus.req1_a  : bus.req0_a;
                alu_b_q  <= gnt ? bus.req1_b  : bus.req0_b;
                alu_op_q <= gnt ? bus.req1_op : bus.req0_op;
                rsp_id_q <= gnt;
                prio_q   <= ~gnt;
                cnt_q    <= CNT_INIT;
            end else if (state_q == EXEC && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (capture) begin
                rsp_data_q  <= bus.alu_res;
                rsp_valid_q <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Ready is gated by reset so nothing appears accepted while held in reset.
    assign bus.req0_ready = rst_n & (state_q == IDLE) & any_valid & ~gnt;
    assign bus.req1_ready = rst_n & (state_q == IDLE) & any_valid &  gnt;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;
    logic v0, v1, rsp_rdy;
    logic [2:0] a0, b0, op0, a1, b1, op1;

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter_if #(.DW(3), .OPW(3), .RW(5)) if0 ();
    alu_share_arbiter_if #(.DW(3), .OPW(3), .RW(5)) if1 ();

    alu_share_arbiter #(.DW(3), .OPW(3), .RW(5), .ALU_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    alu_share_arbiter #(.DW(3), .OPW(3), .RW(5), .ALU_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    function automatic logic [4:0] alu_fn(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return 5'(a) + 5'(b);
            3'd1:    return 5'(a) - 5'(b);
            3'd2:    return {2'b00, a & b};
            3'd3:    return {2'b00, a | b};
            3'd4:    return {2'b00, a ^ b};
            3'd5:    return {a[1:0], b};
            3'd6:    return {2'b00, ~a};
            default: return 5'(a) + 5'd1;
        endcase
    endfunction

    assign if0.req0_valid = v0;  assign if1.req0_valid = v0;
    assign if0.req1_valid = v1;  assign if1.req1_valid = v1;
    assign if0.req0_a = a0;      assign if1.req0_a = a0;
    assign if0.req0_b = b0;      assign if1.req0_b = b0;
    assign if0.req0_op = op0;    assign if1.req0_op = op0;
    assign if0.req1_a = a1;      assign if1.req1_a = a1;
    assign if0.req1_b = b1;      assign if1.req1_b = b1;
    assign if0.req1_op = op1;    assign if1.req1_op = op1;
    assign if0.rsp_ready = rsp_rdy;
    assign if1.rsp_ready = rsp_rdy;
    assign if0.alu_res = alu_fn(if0.alu_a, if0.alu_b, if0.alu_op);
    assign if1.alu_res = alu_fn(if1.alu_a, if1.alu_b, if1.alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: one op in flight per DUT, stamped with
    // the cycle it was accepted; the response is due lat cycles later.
    int         lat [2] = '{1, 3};
    int         cyc = 0;
    bit         pend [2];
    int         tacc [2];
    bit         mprio [2];
    logic [2:0] ma [2], mb [2], mop [2];
    logic [4:0] mres [2], mdata [2];
    bit         mid [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend[d] = 0; mprio[d] = 0; mid[d] = 0;
                ma[d] = 0; mb[d] = 0; mop[d] = 0; mres[d] = 0; mdata[d] = 0;
            end else if (pend[d]) begin
                if ((cyc - tacc[d] >= lat[d]) && rsp_rdy) pend[d] = 0;
            end else if (v0 || v1) begin
                bit w;
                w = (v0 && v1) ? mprio[d] : v1;
                ma[d]  = w ? a1 : a0;
                mb[d]  = w ? b1 : b0;
                mop[d] = w ? op1 : op0;
                mres[d] = alu_fn(ma[d], mb[d], mop[d]);
                mid[d] = w;
                mprio[d] = !w;
                pend[d] = 1;
                tacc[d] = cyc + 1;
            end
        end
        cyc++;
        for (int d = 0; d < 2; d++)
            if (pend[d] && (cyc - tacc[d] == lat[d])) mdata[d] = mres[d];
    endfunction

    task automatic check_dut(input int d, input logic r0, input logic r1, input logic bsy,
                             input logic [2:0] xa, input logic [2:0] xb, input logic [2:0] xop,
                             input logic vld, input logic [4:0] dat, input logic id);
        bit ev, w, er0, er1;
        ev  = pend[d] && (cyc - tacc[d] >= lat[d]);
        w   = (v0 && v1) ? mprio[d] : v1;
        er0 = rst_n && !pend[d] && (v0 || v1) && !w;
        er1 = rst_n && !pend[d] && (v0 || v1) && w;
        chk($sformatf("d%0d_ready0", d), 32'(r0), 32'(er0));
        chk($sformatf("d%0d_ready1", d), 32'(r1), 32'(er1));
        chk($sformatf("d%0d_busy", d), 32'(bsy), 32'(pend[d]));
        chk($sformatf("d%0d_alu_a", d), 32'(xa), 32'(ma[d]));
        chk($sformatf("d%0d_alu_b", d), 32'(xb), 32'(mb[d]));
        chk($sformatf("d%0d_alu_op", d), 32'(xop), 32'(mop[d]));
        chk($sformatf("d%0d_rsp_valid", d), 32'(vld), 32'(ev));
        chk($sformatf("d%0d_rsp_data", d), 32'(dat), 32'(mdata[d]));
        chk($sformatf("d%0d_rsp_id", d), 32'(id), 32'(mid[d]));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_dut(0, if0.req0_ready, if0.req1_ready, if0.busy, if0.alu_a, if0.alu_b,
                  if0.alu_op, if0.rsp_valid, if0.rsp_data, if0.rsp_id);
        check_dut(1, if1.req0_ready, if1.req1_ready, if1.busy, if1.alu_a, if1.alu_b,
                  if1.alu_op, if1.rsp_valid, if1.rsp_data, if1.rsp_id);
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0; rsp_rdy = 1;
        rst_n = 0;
        step_cycle();
        rst_n = 1;
    endtask

    task automatic rand_ops();
        a0 = 3'($urandom); b0 = 3'($urandom); op0 = 3'($urandom);
        a1 = 3'($urandom); b1 = 3'($urandom); op1 = 3'($urandom);
    endtask

    int   gq [$];
    logic [4:0] hold_data;
    logic hold_id;

    initial begin
        // 1: reset with random inputs, then release
        rst_n = 0;
        rand_ops();
        v0 = 1'($urandom); v1 = 1'($urandom); rsp_rdy = 1'($urandom);
        repeat (3) step_cycle();
        rst_n = 1;
        v0 = 1; v1 = 0; a0 = 3'd7; b0 = 3'd4; op0 = 3'd0; rsp_rdy = 1;
        #1 chk("t1_ready0", 32'(if0.req0_ready), 32'd1);

        // 2: single request, A+B with ALU_LAT=1
        step_cycle();
        chk("t2_alu_a", 32'(if0.alu_a), 32'd7);
        chk("t2_alu_b", 32'(if0.alu_b), 32'd4);
        v0 = 0;
        step_cycle();
        chk("t2_rsp_valid", 32'(if0.rsp_valid), 32'd1);
        chk("t2_rsp_data", 32'(if0.rsp_data), 32'b01011);
        chk("t2_rsp_id", 32'(if0.rsp_id), 32'd0);
        repeat (5) step_cycle();

        // 3: both requesters always valid, grants must alternate
        do_reset();
        v0 = 1; v1 = 1; rsp_rdy = 1;
        for (int k = 0; k < 100 && gq.size() < 8; k++) begin
            rand_ops();
            #1;
            if (if0.req0_ready) gq.push_back(0);
            else if (if0.req1_ready) gq.push_back(1);
            step_cycle();
        end
        v0 = 0; v1 = 0;
        chk("t3_grant_count", 32'(gq.size()), 32'd8);
        foreach (gq[i]) chk($sformatf("t3_grant%0d", i), 32'(gq[i]), 32'(i % 2));
        repeat (6) step_cycle();

        // 4: backpressure in RESP
        do_reset();
        v0 = 1; rsp_rdy = 0; rand_ops();
        step_cycle();
        v0 = 0;
        for (int k = 0; k < 10 && !if0.rsp_valid; k++) step_cycle();
        chk("t4_reach_resp", 32'(if0.rsp_valid), 32'd1);
        hold_data = if0.rsp_data;
        hold_id = if0.rsp_id;
        v0 = 1; v1 = 1;
        for (int k = 0; k < 5; k++) begin
            step_cycle();
            chk("t4_valid", 32'(if0.rsp_valid), 32'd1);
            chk("t4_data", 32'(if0.rsp_data), 32'(hold_data));
            chk("t4_id", 32'(if0.rsp_id), 32'(hold_id));
            chk("t4_ready0", 32'(if0.req0_ready), 32'd0);
            chk("t4_ready1", 32'(if0.req1_ready), 32'd0);
            chk("t4_busy", 32'(if0.busy), 32'd1);
        end
        v0 = 0; v1 = 0; rsp_rdy = 1;
        repeat (6) step_cycle();

        // 5: ALU_LAT=3, A-B
        do_reset();
        v0 = 1; a0 = 3'd5; b0 = 3'd2; op0 = 3'd1; rsp_rdy = 1;
        step_cycle();
        v0 = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5_not_yet%0d", k), 32'(if1.rsp_valid), 32'd0);
            step_cycle();
        end
        chk("t5_rsp_valid", 32'(if1.rsp_valid), 32'd1);
        chk("t5_rsp_data", 32'(if1.rsp_data), 32'd3);
        repeat (3) step_cycle();

        // 6: reset during EXEC drops the op and restores priority
        do_reset();
        v0 = 0; v1 = 1; rand_ops();
        step_cycle();
        v1 = 0;
        chk("t6_in_exec", 32'(if1.busy), 32'd1);
        rst_n = 0;
        step_cycle();
        chk("t6_no_rsp", 32'(if1.rsp_valid), 32'd0);
        rst_n = 1;
        v0 = 1; v1 = 1;
        #1;
        chk("t6_ready0", 32'(if1.req0_ready), 32'd1);
        chk("t6_ready1", 32'(if1.req1_ready), 32'd0);
        step_cycle();
        v0 = 0; v1 = 0;
        repeat (6) step_cycle();

        // randomized traffic with occasional asynchronous resets
        for (int k = 0; k < 500; k++) begin
            rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            v0 = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 1) == 1);
            rsp_rdy = ($urandom_range(0, 9) < 6);
            rand_ops();
            step_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
